// File: rtl/dmem_arbiter_if.sv
// Bundle of processor, debug and memory-side signals
// shared by dmem_arbiter and its surroundings.
interface dmem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-cycle arbiter between CPU load/store and debug port.
// Define DMEM_ARB_STARVE_GUARD_EN to add the debug starvation guard.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESP_CPU = 2'd1,
        RESP_DBG = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic issue_ok;
    logic force_dbg;
    logic grant_cpu;
    logic grant_dbg;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.cpu_addr[1:0],
                                bus.dbg_addr[1:0]};

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT outside 1..255");
    end

    // Nothing is issued while held in reset or awaiting a response.
    assign issue_ok  = rst_n & (state_q == IDLE);
    assign grant_dbg = issue_ok & bus.dbg_req &
                       (~bus.cpu_req | force_dbg);
    assign grant_cpu = issue_ok & bus.cpu_req & ~grant_dbg;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic [7:0] starve_q;

    assign force_dbg = (starve_q == 8'(STARVE_LIMIT));

    // Count CPU wins over a waiting debug request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 8'd0;
        end else if (!bus.dbg_req || grant_dbg) begin
            starve_q <= 8'd0;
        end else if (grant_cpu) begin
            starve_q <= starve_q + 8'd1;
        end
    end
`else
    assign force_dbg = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: issue moves to its response, response returns.
    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE: begin
                if (grant_cpu) begin
                    state_d = RESP_CPU;
                end else if (grant_dbg) begin
                    state_d = RESP_DBG;
                end
            end
            RESP_CPU: state_d = IDLE;
            RESP_DBG: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs: winner drives the memory command, responses pass data.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_be    = 4'd0;
        unique case (1'b1)
            grant_cpu: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = bus.cpu_we;
                bus.mem_addr  = {bus.cpu_addr[31:2], 2'b00};
                bus.mem_wdata = bus.cpu_wdata;
                bus.mem_be    = bus.cpu_be;
            end
            grant_dbg: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = bus.dbg_we;
                bus.mem_addr  = {bus.dbg_addr[31:2], 2'b00};
                bus.mem_wdata = bus.dbg_wdata;
                bus.mem_be    = 4'hF;
            end
            default: ;
        endcase
        bus.cpu_stall = bus.cpu_req & (state_q != RESP_CPU);
        bus.cpu_rdata = (state_q == RESP_CPU) ?
                        bus.mem_rdata : 32'd0;
        bus.dbg_ack   = (state_q == RESP_DBG);
    end

    // Debug read data is held until the next debug load completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dbg_rdata <= 32'd0;
        end else if (state_q == RESP_DBG && !bus.dbg_we) begin
            bus.dbg_rdata <= bus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter with a
// byte-array memory and a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int LIM = 3;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init = 1'b1;

    dmem_arbiter_if bus();

    dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  tmem    [0:255];
    logic [7:0]  ref_mem [0:255];
    int          vec_n = 0;
    int          err_n = 0;
    logic [31:0] exp_dbg;

    // Synchronous byte-lane memory seen by the arbiter.
    always @(posedge clk) begin
        logic [7:0] a;
        a = bus.mem_addr[7:0];
        if (init) begin
            for (int i = 0; i < 256; i++) tmem[i] <= 8'h00;
            bus.mem_rdata <= 32'd0;
        end else if (bus.mem_en) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_we && bus.mem_be[i])
                    tmem[a + 8'(i)] <= bus.mem_wdata[8*i +: 8];
            end
            bus.mem_rdata <= {tmem[a + 8'd3], tmem[a + 8'd2],
                              tmem[a + 8'd1], tmem[a]};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vec_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        logic [7:0] b;
        b = {addr[7:2], 2'b00};
        return {ref_mem[b + 8'd3], ref_mem[b + 8'd2],
                ref_mem[b + 8'd1], ref_mem[b]};
    endfunction

    task automatic ref_store(input logic [31:0] addr,
                             input logic [31:0] data,
                             input logic [3:0] be);
        logic [7:0] b;
        b = {addr[7:2], 2'b00};
        for (int i = 0; i < 4; i++)
            if (be[i]) ref_mem[b + 8'(i)] = data[8*i +: 8];
    endtask

    task automatic cpu_access(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata,
                              input logic [3:0] be);
        logic [31:0] exp;
        @(negedge clk);
        bus.cpu_req = 1'b1;
        bus.cpu_we = we;
        bus.cpu_addr = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_be = be;
        #1;
        check("cpu_issue_stall", 32'(bus.cpu_stall), 32'd1);
        check("cpu_issue_en", 32'(bus.mem_en), 32'd1);
        check("cpu_issue_we", 32'(bus.mem_we), 32'(we));
        check("cpu_issue_addr", bus.mem_addr, {addr[31:2], 2'b00});
        check("cpu_issue_be", 32'(bus.mem_be), 32'(be));
        if (we) check("cpu_issue_wdata", bus.mem_wdata, wdata);
        exp = ref_word(addr);
        @(negedge clk);
        #1;
        check("cpu_resp_stall", 32'(bus.cpu_stall), 32'd0);
        check("cpu_resp_en", 32'(bus.mem_en), 32'd0);
        if (!we) check("cpu_load_data", bus.cpu_rdata, exp);
        else ref_store(addr, wdata, be);
        bus.cpu_req = 1'b0;
    endtask

    task automatic dbg_access(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata);
        logic [31:0] exp;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b1;
        bus.dbg_we = we;
        bus.dbg_addr = addr;
        bus.dbg_wdata = wdata;
        #1;
        check("dbg_issue_en", 32'(bus.mem_en), 32'd1);
        check("dbg_issue_we", 32'(bus.mem_we), 32'(we));
        check("dbg_issue_be", 32'(bus.mem_be), 32'hF);
        check("dbg_issue_addr", bus.mem_addr, {addr[31:2], 2'b00});
        check("dbg_issue_ack", 32'(bus.dbg_ack), 32'd0);
        if (we) check("dbg_issue_wdata", bus.mem_wdata, wdata);
        exp = ref_word(addr);
        @(negedge clk);
        #1;
        check("dbg_resp_ack", 32'(bus.dbg_ack), 32'd1);
        check("dbg_resp_en", 32'(bus.mem_en), 32'd0);
        if (we) ref_store(addr, wdata, 4'hF);
        else exp_dbg = exp;
        bus.dbg_req = 1'b0;
        @(negedge clk);
        #1;
        check("dbg_ack_pulse", 32'(bus.dbg_ack), 32'd0);
        check("dbg_rdata", bus.dbg_rdata, exp_dbg);
    endtask

    initial begin
        logic [31:0] ca;
        logic [31:0] exp;
        int          cpu_done;
        int          cwins;
        int          dbg_slot;
        bit          dbg_done;
        bit          dbg_issue;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        exp_dbg = 32'd0;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 32'd0;
        bus.cpu_wdata = 32'd0;
        bus.cpu_be = 4'd0;
        bus.dbg_req = 1'b0;
        bus.dbg_we = 1'b0;
        bus.dbg_addr = 32'd0;
        bus.dbg_wdata = 32'd0;

        // Reset values, with requests present.
        repeat (2) @(negedge clk);
        bus.cpu_req = 1'b1;
        bus.dbg_req = 1'b1;
        bus.cpu_addr = 32'h0000_0044;
        bus.cpu_be = 4'hF;
        #1;
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_mem_be", 32'(bus.mem_be), 32'd0);
        check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        check("rst_stall_hi", 32'(bus.cpu_stall), 32'd1);
        check("rst_dbg_ack", 32'(bus.dbg_ack), 32'd0);
        check("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        #1;
        check("rst_stall_lo", 32'(bus.cpu_stall), 32'd0);
        @(negedge clk);
        init = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_no_en", 32'(bus.mem_en), 32'd0);

        // Full-word store then load at 12.
        cpu_access(1'b1, 32'd12, 32'h0000_0004, 4'hF);
        check("st12_b12", 32'(tmem[12]), 32'h04);
        check("st12_b13", 32'(tmem[13]), 32'h00);
        check("st12_b14", 32'(tmem[14]), 32'h00);
        check("st12_b15", 32'(tmem[15]), 32'h00);
        cpu_access(1'b0, 32'd12, 32'd0, 4'hF);

        // Single lane, then an all-lanes-off store.
        cpu_access(1'b1, 32'd16, 32'hAABB_CCDD, 4'b0010);
        check("lane_b16", 32'(tmem[16]), 32'h00);
        check("lane_b17", 32'(tmem[17]), 32'hCC);
        check("lane_b18", 32'(tmem[18]), 32'h00);
        check("lane_b19", 32'(tmem[19]), 32'h00);
        cpu_access(1'b1, 32'd16, 32'h1122_3344, 4'b0000);
        check("be0_b17", 32'(tmem[17]), 32'hCC);
        check("be0_b16", 32'(tmem[16]), 32'h00);
        cpu_access(1'b0, 32'd18, 32'd0, 4'hF);

        // Random CPU traffic, avoiding the word at 12.
        for (int n = 0; n < 40; n++) begin
            ca = $urandom;
            if (ca[7:2] == 6'd3) ca[7] = 1'b1;
            cpu_access(1'($urandom), ca, $urandom, 4'($urandom));
        end

        // Random debug traffic plus cross-port visibility.
        for (int n = 0; n < 8; n++) begin
            ca = $urandom;
            if (ca[7:2] == 6'd3) ca[6] = 1'b1;
            dbg_access(1'($urandom), ca, $urandom);
        end
        dbg_access(1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
        cpu_access(1'b0, 32'h0000_0021, 32'd0, 4'hF);
        cpu_access(1'b1, 32'h0000_0024, 32'h5A5A_0F0F, 4'b1001);
        dbg_access(1'b0, 32'h0000_0027, 32'd0);

        // Contention: CPU streams 20 loads, debug loads word 12.
        cpu_done = 0;
        cwins = 0;
        dbg_done = 1'b0;
        dbg_slot = -1;
        bus.dbg_we = 1'b0;
        bus.dbg_addr = 32'd14;
        for (int s = 0; s < 40; s++) begin
            if (dbg_done && cpu_done == 20) break;
            @(negedge clk);
            bus.dbg_req = !dbg_done;
            bus.cpu_req = (cpu_done < 20);
            ca = $urandom;
            bus.cpu_we = 1'b0;
            bus.cpu_addr = ca;
            bus.cpu_be = 4'($urandom);
            #1;
            dbg_issue = !dbg_done &&
                        (!bus.cpu_req || (GUARD && cwins == LIM));
            exp = ref_word(ca);
            if (dbg_issue) begin
                check("cont_dbg_be", 32'(bus.mem_be), 32'hF);
                check("cont_dbg_addr", bus.mem_addr, 32'd12);
            end else if (bus.cpu_req) begin
                check("cont_cpu_be", 32'(bus.mem_be),
                      32'(bus.cpu_be));
                check("cont_cpu_addr", bus.mem_addr,
                      {ca[31:2], 2'b00});
            end
            check("cont_issue_stall", 32'(bus.cpu_stall),
                  32'(bus.cpu_req));
            @(negedge clk);
            #1;
            check("cont_ack", 32'(bus.dbg_ack), 32'(dbg_issue));
            if (bus.dbg_ack && dbg_slot < 0) dbg_slot = s;
            if (dbg_issue) begin
                check("cont_dbg_stall", 32'(bus.cpu_stall),
                      32'(bus.cpu_req));
                dbg_done = 1'b1;
                cwins = 0;
            end else if (bus.cpu_req) begin
                check("cont_cpu_data", bus.cpu_rdata, exp);
                check("cont_cpu_stall", 32'(bus.cpu_stall), 32'd0);
                cpu_done++;
                if (!dbg_done) cwins++;
            end
        end
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        check("cont_cpu_count", 32'(cpu_done), 32'd20);
        check("cont_dbg_done", 32'(dbg_done), 32'd1);
        check("cont_dbg_slot", 32'(dbg_slot),
              GUARD ? 32'(LIM) : 32'd20);
        @(negedge clk);
        #1;
        exp_dbg = ref_word(32'd12);
        check("cont_dbg_rdata", bus.dbg_rdata, 32'd4);

        // Reset asserted while the debug response is pending.
        @(negedge clk);
        bus.dbg_req = 1'b1;
        bus.dbg_we = 1'b0;
        bus.dbg_addr = 32'd16;
        #1;
        check("mid_issue_en", 32'(bus.mem_en), 32'd1);
        @(negedge clk);
        #1;
        check("mid_in_resp", 32'(bus.dbg_ack), 32'd1);
        rst_n = 1'b0;
        bus.cpu_req = 1'b1;
        #1;
        check("mid_ack", 32'(bus.dbg_ack), 32'd0);
        check("mid_en", 32'(bus.mem_en), 32'd0);
        check("mid_addr", bus.mem_addr, 32'd0);
        check("mid_be", 32'(bus.mem_be), 32'd0);
        check("mid_cpu_rdata", bus.cpu_rdata, 32'd0);
        check("mid_dbg_rdata", bus.dbg_rdata, 32'd0);
        check("mid_stall_hi", 32'(bus.cpu_stall), 32'd1);
        bus.cpu_req = 1'b0;
        #1;
        check("mid_stall_lo", 32'(bus.cpu_stall), 32'd0);
        @(negedge clk);
        #1;
        check("mid_hold_ack", 32'(bus.dbg_ack), 32'd0);
        rst_n = 1'b1;
        bus.dbg_req = 1'b0;
        @(negedge clk);
        #1;
        check("post_ack", 32'(bus.dbg_ack), 32'd0);
        check("post_en", 32'(bus.mem_en), 32'd0);
        exp_dbg = 32'd0;
        cpu_access(1'b0, 32'd12, 32'd0, 4'hF);
        dbg_access(1'b0, 32'd16, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_n, err_n);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-ported, byte-addressed data memory between the processor's load/store path and a debug/loader port. Each access is a fixed two-cycle transaction: issue, then response. The block stalls the processor while its access is pending or the debug port owns the memory. It sits between the processor datapath (ALU result, register read data) and `dmemory`; memory words are little-endian, so a word written to address 12 stores its LSB in byte 12.

## Interface
Parameters:
- `STARVE_LIMIT`, default 8: consecutive lost arbitrations after which the debug port is forced through. Used only with the guard compiled in. Legal range 1–255.

Ports:
- `clk` in 1: processor clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: processor memory access; held until the cycle `cpu_stall` is low.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address. Bits [1:0] are ignored for word alignment.
- `cpu_wdata` in 32: store data.
- `cpu_be` in 4: byte enables; bit i controls byte lane i (address+i).
- `cpu_rdata` out 32: load data, valid in the `RESP_CPU` cycle.
- `cpu_stall` out 1: freeze the PC and register writeback.
- `dbg_req` in 1: debug access; held until `dbg_ack`.
- `dbg_we` in 1, `dbg_addr` in 32, `dbg_wdata` in 32: debug access fields. Debug accesses are always full-word.
- `dbg_ack` out 1: one-cycle completion pulse.
- `dbg_rdata` out 32: registered; captured at the ack and held until the next debug load ack.
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32, `mem_be` out 4: memory command.
- `mem_rdata` in 32: synchronous read data, valid one cycle after `mem_en`.

## Operation
- FSM states: `IDLE`, `RESP_CPU`, `RESP_DBG`. Reset state is `IDLE`.
- In `IDLE`, a winner is chosen combinationally:
  - Default: CPU wins whenever `cpu_req` is high.
  - Debug wins when `cpu_req` is low, or when the starvation guard fires.
- The winner's fields drive `mem_*` in the same cycle with `mem_en` = 1. `mem_addr` = {addr[31:2], 2'b00}; `mem_be` = `cpu_be` for CPU, 4'hF for debug.
- The FSM then moves to `RESP_CPU` or `RESP_DBG`. If neither port requests, `mem_en` = 0 and the FSM stays in `IDLE`.
- `RESP_CPU`: `cpu_rdata` = `mem_rdata` (combinational pass-through); `cpu_stall` = 0. Next state is `IDLE`.
- `RESP_DBG`: `dbg_ack` = 1; `dbg_rdata` is loaded with `mem_rdata` if `dbg_we` = 0. Next state is `IDLE`.
- `cpu_stall` = `cpu_req` & (state != `RESP_CPU`).
- `mem_en` = 0 in both RESP states; there is no issue/response overlap.
- Outside `RESP_CPU`, `cpu_rdata` = 0.
- Stores: a zero `cpu_be` is still issued, with `mem_en` = 1, `mem_we` = 1 and no bytes changed.
- Requests must not drop while pending. If `dbg_req` drops during `RESP_DBG`, the ack is still issued.

## Timing
- Reset values: `mem_en`/`mem_we` 0; `mem_addr`/`mem_wdata` 0; `mem_be` 0; `cpu_rdata` 0; `cpu_stall` = `cpu_req`; `dbg_ack` 0; `dbg_rdata` 0; starvation counter 0.
- Latency: 2 cycles per access, issue cycle N and response cycle N+1. Peak throughput is one access per 2 cycles.
- Simultaneous requests in `IDLE`: CPU first (subject to the guard). Debug is served in the next `IDLE` if `cpu_req` is low, or once the guard fires.
- Reset asserted mid-transaction: the FSM returns to `IDLE` immediately and the pending response is dropped (no `dbg_ack`). An issued write may already have committed.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN` defined:
  - An 8-bit counter increments on each `IDLE` cycle where both ports request and the CPU wins.
  - When the counter equals `STARVE_LIMIT`, debug wins the next `IDLE` arbitration.
  - The counter clears on any debug grant, or whenever `dbg_req` = 0.
- Undefined: no counter; strict CPU priority, so the debug port can starve indefinitely.

## Test plan
- **CPU store/load:** store 32'h00000004 at addr 12 with `cpu_be` = 4'hF. Then: bytes 12..15 = 04,00,00,00; a load from addr 12 returns 4 in the `RESP_CPU` cycle; `cpu_stall` is high exactly 1 cycle per access.
- **Byte-lane store:** `cpu_be` = 4'b0010 with data 32'hAABBCCDD to addr 16. Then: only byte 17 = CC; a `cpu_be` = 0 store changes nothing.
- **Contention without guard:** `cpu_req` held high for 20 accesses plus a debug load of addr 12. Then: `dbg_ack` only after `cpu_req` drops; `dbg_rdata` = 4.
- **Contention with guard:** `STARVE_LIMIT` = 3, guard compiled in, both ports continuously requesting. Then: the debug grant occurs in the 4th `IDLE` cycle, the counter resets, and the CPU resumes.
- **Reset mid-transaction:** `rst_n` pulsed low during `RESP_DBG`. Then: no `dbg_ack`; all outputs at reset values; `cpu_stall` follows `cpu_req`; the FSM is in `IDLE` after release.
